dcache_ctrl: RTL and testbench

Direct-mapped, write-back, write-allocate data cache controller. It answers the pipeline's MEM-stage load/store requests and replaces the flat single-cycle data memory. Hits are served combinationally with no stall. Misses stall the pipeline while the block runs a line write-back and/or refill on a handshaked off-chip memory port.

---
 rtl/dcache_pkg.sv | 41 ++++
 rtl/dcache_sram.sv | 55 +++++
 rtl/dcache_ctrl.sv | 136 +++++++++++++
 tb/tb_dcache_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// Shared types and constants for the direct-mapped write-back data cache.
package dcache_pkg;

  localparam int ADDR_W     = 32;
  localparam int WORD_W     = 32;
  localparam int LINES      = 32;
  localparam int LINE_BYTES = 32;
  localparam int LINE_W     = LINE_BYTES * 8;

  localparam int TAG_W  = 22;
  localparam int IDX_W  = 5;
  localparam int OFS_W  = 5;
  localparam int WSEL_W = 3;

  // Byte-address field boundaries
  localparam int WSEL_LSB = 2;
  localparam int WSEL_MSB = 4;
  localparam int IDX_LSB  = 5;
  localparam int IDX_MSB  = 9;
  localparam int TAG_LSB  = 10;
  localparam int TAG_MSB  = 31;

  typedef enum logic [1:0] {
    IDLE,
    WRITEBACK,
    ALLOCATE
  } state_t;

  typedef struct packed {
    logic             valid;
    logic             dirty;
    logic [TAG_W-1:0] tag;
  } line_meta_t;

  // Line-aligned byte address from a tag and an index.
  function automatic logic [ADDR_W-1:0] line_addr(input logic [TAG_W-1:0] tag,
                                                  input logic [IDX_W-1:0] idx);
    return {tag, idx, {OFS_W{1'b0}}};
  endfunction

endpackage

// File: rtl/dcache_sram.sv
// Single-port line storage: per-line valid/dirty/tag plus 256-bit data.
// One index serves both the read and the write; a word write dirties the
// line, a whole-line write installs a clean valid line with a new tag.
module dcache_sram
  import dcache_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IDX_W-1:0]  idx,
  input  logic              word_we,
  input  logic [WSEL_W-1:0] wsel,
  input  logic [WORD_W-1:0] wdata,
  input  logic              line_we,
  input  logic [TAG_W-1:0]  line_tag,
  input  logic [LINE_W-1:0] line_wdata,
  output logic              valid,
  output logic              dirty,
  output logic [TAG_W-1:0]  tag,
  output logic [LINE_W-1:0] line_rdata
);

  logic [LINES-1:0]  valid_q;
  logic [LINES-1:0]  dirty_q;
  logic [TAG_W-1:0]  tag_mem  [LINES];
  logic [LINE_W-1:0] data_mem [LINES];

  // Valid/dirty are the only state cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (line_we) begin
      valid_q[idx] <= 1'b1;
      dirty_q[idx] <= 1'b0;
    end else if (word_we) begin
      dirty_q[idx] <= 1'b1;
    end
  end

  // Tag and data arrays keep their contents across reset.
  always_ff @(posedge clk) begin
    if (line_we) begin
      tag_mem[idx]  <= line_tag;
      data_mem[idx] <= line_wdata;
    end else if (word_we) begin
      data_mem[idx][{wsel, 5'b0} +: WORD_W] <= wdata;
    end
  end

  assign valid      = valid_q[idx];
  assign dirty      = dirty_q[idx];
  assign tag        = tag_mem[idx];
  assign line_rdata = data_mem[idx];

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache controller.
// Hits complete combinationally; a miss stalls the pipeline while the
// victim line is written back (if dirty) and the new line is refilled.
// The missing line address is latched so a fill lands in the right line
// even if the CPU drops its request mid-miss.
module dcache_ctrl
  import dcache_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [WORD_W-1:0] wdata_i,
  output logic [WORD_W-1:0] rdata_o,
  output logic              stall_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [LINE_W-1:0] mem_wdata_o,
  input  logic [LINE_W-1:0] mem_rdata_i,
  input  logic              mem_ack_i
);

  state_t                   state;
  logic [TAG_W-1:0]         miss_tag;
  logic [IDX_W-1:0]         miss_idx;

  logic [TAG_W-1:0]         req_tag;
  logic [IDX_W-1:0]         req_idx;
  logic [WSEL_W-1:0]        req_wsel;
  logic [IDX_W-1:0]         sram_idx;
  line_meta_t               meta;
  logic [LINE_W-1:0]        line_data;
  logic                     idle;
  logic                     hit;
  logic                     miss;
  logic                     victim_dirty;
  logic                     word_we;
  logic                     line_we;
  logic                     unused_addr_bits;

  assign req_tag          = addr_i[TAG_MSB:TAG_LSB];
  assign req_idx          = addr_i[IDX_MSB:IDX_LSB];
  assign req_wsel         = addr_i[WSEL_MSB:WSEL_LSB];
  assign unused_addr_bits = ^addr_i[1:0];

  assign idle         = (state == IDLE);
  // Outside IDLE the array is addressed by the latched miss line.
  assign sram_idx     = idle ? req_idx : miss_idx;
  assign hit          = req_i & meta.valid & (meta.tag == req_tag);
  assign miss         = req_i & ~hit;
  assign victim_dirty = meta.valid & meta.dirty;
  assign stall_o      = ~idle | miss;

  assign word_we = idle & hit & we_i;
  assign line_we = (state == ALLOCATE) & mem_ack_i;

  assign rdata_o = hit ? line_data[{req_wsel, 5'b0} +: WORD_W] : '0;

  dcache_sram u_sram (
    .clk        (clk_i),
    .rst_n      (rst_i),
    .idx        (sram_idx),
    .word_we    (word_we),
    .wsel       (req_wsel),
    .wdata      (wdata_i),
    .line_we    (line_we),
    .line_tag   (miss_tag),
    .line_wdata (mem_rdata_i),
    .valid      (meta.valid),
    .dirty      (meta.dirty),
    .tag        (meta.tag),
    .line_rdata (line_data)
  );

  // Miss sequencing FSM with registered memory-port request, direction and address.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state      <= IDLE;
      mem_req_o  <= 1'b0;
      mem_we_o   <= 1'b0;
      mem_addr_o <= '0;
      miss_tag   <= '0;
      miss_idx   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (miss) begin
            miss_tag  <= req_tag;
            miss_idx  <= req_idx;
            mem_req_o <= 1'b1;
            if (victim_dirty) begin
              state      <= WRITEBACK;
              mem_we_o   <= 1'b1;
              mem_addr_o <= line_addr(meta.tag, req_idx);
            end else begin
              state      <= ALLOCATE;
              mem_we_o   <= 1'b0;
              mem_addr_o <= line_addr(req_tag, req_idx);
            end
          end
        end
        WRITEBACK: begin
          if (mem_ack_i) begin
            state      <= ALLOCATE;
            mem_we_o   <= 1'b0;
            mem_addr_o <= line_addr(miss_tag, miss_idx);
          end
        end
        ALLOCATE: begin
          if (mem_ack_i) begin
            state     <= IDLE;
            mem_req_o <= 1'b0;
            mem_we_o  <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          mem_req_o <= 1'b0;
          mem_we_o  <= 1'b0;
        end
      endcase
    end
  end

  // Victim line is captured at miss time so write-back data holds steady until ack.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      mem_wdata_o <= '0;
    end else if (idle & miss & victim_dirty) begin
      mem_wdata_o <= line_data;
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: directed scenarios followed by
// random loads/stores, all compared against a line-level cache and
// memory model kept in the bench.
module tb_dcache_ctrl;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b0;
  logic         req_i = 1'b0;
  logic         we_i = 1'b0;
  logic [31:0]  addr_i = '0;
  logic [31:0]  wdata_i = '0;
  logic [31:0]  rdata_o;
  logic         stall_o;
  logic         mem_req_o;
  logic         mem_we_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_wdata_o;
  logic [255:0] mem_rdata_i = '0;
  logic         mem_ack_i = 1'b0;

  dcache_ctrl dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .req_i       (req_i),
    .we_i        (we_i),
    .addr_i      (addr_i),
    .wdata_i     (wdata_i),
    .rdata_o     (rdata_o),
    .stall_o     (stall_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_rdata_i (mem_rdata_i),
    .mem_ack_i   (mem_ack_i)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: cache contents per line and backing memory per line address.
  bit           m_valid [32];
  bit           m_dirty [32];
  logic [21:0]  m_tag   [32];
  logic [255:0] m_data  [32];
  logic [255:0] mem     [logic [31:0]];

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  function automatic logic [255:0] mem_read(input logic [31:0] a);
    logic [255:0] l;
    if (mem.exists(a)) return mem[a];
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = a ^ (32'h5A00_0000 + 32'(i));
    return l;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
  endtask

  // One CPU access, with the bench acting as memory answering after lat cycles.
  task automatic access(input bit we, input logic [31:0] addr, input logic [31:0] wd,
                        input int lat);
    int          idx;
    int          wi;
    logic [21:0] tg;
    bit          exp_hit;
    bit          exp_wb;
    int          exp_stall;
    int          nph;
    logic [31:0] ex_addr [2];
    bit          ex_we   [2];
    logic [31:0] al_addr;
    logic [31:0] a0;
    int          stalls;
    int          ph;
    int          cyc;
    int          k;
    bit          done;

    idx     = int'(addr[9:5]);
    wi      = int'(addr[4:2]);
    tg      = addr[31:10];
    al_addr = {tg, addr[9:5], 5'b0};
    exp_hit = m_valid[idx] && (m_tag[idx] == tg);
    exp_wb  = !exp_hit && m_valid[idx] && m_dirty[idx];
    exp_stall = exp_hit ? 0 : (exp_wb ? 2*lat + 1 : lat + 1);
    nph = 0;
    if (exp_wb) begin
      ex_addr[0] = {m_tag[idx], addr[9:5], 5'b0}; ex_we[0] = 1'b1;
      ex_addr[1] = al_addr;                       ex_we[1] = 1'b0;
      nph = 2;
    end else if (!exp_hit) begin
      ex_addr[0] = al_addr; ex_we[0] = 1'b0;
      ex_addr[1] = al_addr; ex_we[1] = 1'b0;
      nph = 1;
    end else begin
      ex_addr[0] = '0; ex_we[0] = 1'b0;
      ex_addr[1] = '0; ex_we[1] = 1'b0;
    end

    @(negedge clk_i);
    req_i = 1'b1; we_i = we; addr_i = addr; wdata_i = wd;
    stalls = 0; ph = 0; cyc = 0; k = 0; done = 1'b0; a0 = '0;
    while (!done) begin
      #1;
      if (!stall_o) begin
        done = 1'b1;
      end else begin
        stalls++;
        if (mem_req_o) begin
          if (cyc == 0) begin
            a0 = mem_addr_o;
            if (ph < nph) begin
              chk("mem_we", 256'(mem_we_o), 256'(ex_we[ph]));
              chk("mem_addr", 256'(mem_addr_o), 256'(ex_addr[ph]));
              if (ex_we[ph]) chk("wb_data", mem_wdata_o, m_data[idx]);
            end else begin
              chk("extra_phase", 256'(ph), 256'(nph));
            end
          end
          cyc++;
          if (cyc >= lat) begin
            chk("addr_stable", 256'(mem_addr_o), 256'(a0));
            mem_ack_i   = 1'b1;
            mem_rdata_i = mem_read(al_addr);
            cyc = 0;
            ph++;
          end
        end
        @(negedge clk_i);
        mem_ack_i = 1'b0;
        k++;
        if (k > 100) done = 1'b1;
      end
    end
    chk("stall_cycles", 256'(stalls), 256'(exp_stall));
    chk("phases", 256'(ph), 256'(nph));
    chk("mem_req_done", 256'(mem_req_o), 256'(0));

    if (!exp_hit) begin
      if (exp_wb) mem[{m_tag[idx], addr[9:5], 5'b0}] = m_data[idx];
      m_data[idx]  = mem_read(al_addr);
      m_valid[idx] = 1'b1;
      m_dirty[idx] = 1'b0;
      m_tag[idx]   = tg;
    end
    if (!we) begin
      chk("rdata", 256'(rdata_o), 256'(m_data[idx][wi*32 +: 32]));
    end else begin
      m_data[idx][wi*32 +: 32] = wd;
      m_dirty[idx] = 1'b1;
    end
  endtask

  initial begin
    logic [255:0] pre;
    model_reset();

    // Reset state
    repeat (3) @(negedge clk_i);
    #1;
    chk("rst_mem_req", 256'(mem_req_o), 256'(0));
    chk("rst_mem_we", 256'(mem_we_o), 256'(0));
    chk("rst_mem_addr", 256'(mem_addr_o), 256'(0));
    chk("rst_stall", 256'(stall_o), 256'(0));
    chk("rst_rdata", 256'(rdata_o), 256'(0));
    @(negedge clk_i);
    rst_i = 1'b1;

    // Cold load with known line contents, then store hit and load-after-store
    for (int i = 0; i < 8; i++) pre[i*32 +: 32] = 32'h100 + 32'(i);
    mem[32'h40] = pre;
    access(1'b0, 32'h0000_0040, 32'h0, 3);
    chk("cold_word0", 256'(rdata_o), 256'(32'h100));
    access(1'b1, 32'h0000_0044, 32'hDEAD_BEEF, 3);
    access(1'b0, 32'h0000_0044, 32'h0, 3);
    chk("ld_after_st", 256'(rdata_o), 256'(32'hDEAD_BEEF));

    // Dirty conflict miss, then minimum-latency clean miss
    access(1'b0, 32'h0000_0440, 32'h0, 3);
    chk("wb_merged_word", 256'(mem[32'h40][63:32]), 256'(32'hDEAD_BEEF));
    access(1'b0, 32'h0000_0080, 32'h0, 1);

    // Store miss to clean line, then conflicting miss writes it back
    access(1'b1, 32'h0000_0064, 32'h1234_5678, 2);
    access(1'b0, 32'h0000_0464, 32'h0, 2);

    // Reset during ALLOCATE, then a stray ack while idle
    @(negedge clk_i);
    req_i = 1'b1; we_i = 1'b0; addr_i = 32'h0000_00E0;
    @(negedge clk_i);
    #1;
    chk("alloc_req", 256'(mem_req_o), 256'(1));
    rst_i = 1'b0;
    #1;
    chk("async_drop", 256'(mem_req_o), 256'(0));
    req_i = 1'b0;
    model_reset();
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    #1;
    mem_ack_i = 1'b1;
    @(negedge clk_i);
    mem_ack_i = 1'b0;
    #1;
    chk("late_ack_req", 256'(mem_req_o), 256'(0));
    chk("late_ack_stall", 256'(stall_o), 256'(0));
    access(1'b0, 32'h0000_00E0, 32'h0, 2);
    access(1'b0, 32'h0000_0040, 32'h0, 2);

    // Random loads/stores over a small tag/index pool to force conflicts
    for (int n = 0; n < 150; n++) begin
      logic [31:0] a;
      a = {22'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           3'($urandom_range(0, 7)), 2'b00};
      access(1'($urandom_range(0, 1)), a, $urandom, $urandom_range(1, 4));
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk_i);
        req_i = 1'b0;
        #1;
        chk("idle_stall", 256'(stall_o), 256'(0));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
